alu_req_scheduler: RTL and testbench
====================================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one combinational ALU between two requesters (front-panel loader, debug port).
//  Round-robin arbitration; one operation in flight at a time.
//  Drives the ALU operand/opcode registers, waits a fixed ALU latency, returns the tagged result.
//  Sits between the requester logic and the ALU instance inside the top level.
// PARAMETERS
//  NB_DATA  6  operand/result width (matches ALU data width)
//  NB_OP    6  opcode width (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, ...)
//  ALU_LAT  1  cycles from operand registers valid to result sampled; legal range 1..15
// PORTS
//  clock         in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-low; clears all state
//  i_req0_valid  in   1        requester 0 has an operation pending
//  i_req0_a      in   NB_DATA  requester 0 operand A
//  i_req0_b      in   NB_DATA  requester 0 operand B
//  i_req0_op     in   NB_OP    requester 0 opcode
//  o_req0_ready  out  1        requester 0 operation accepted this cycle if valid
//  i_req1_*      in            same as requester 0 (valid, a, b, op)
//  o_req1_ready  out  1        requester 1 accept
//  o_alu_a       out  NB_DATA  registered operand A to ALU
//  o_alu_b       out  NB_DATA  registered operand B to ALU
//  o_alu_op      out  NB_OP    registered opcode to ALU
//  i_alu_result  in   NB_DATA  ALU result
//  o_rsp_valid   out  1        response valid
//  o_rsp_id      out  1        requester that owns the response (0/1)
//  o_rsp_data    out  NB_DATA  captured ALU result
//  i_rsp_ready   in   1        response consumer ready
//  o_busy        out  1        high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, o_alu_a/b/op=0, o_rsp_valid=0, o_rsp_id=0,
//   o_rsp_data=0, last-grant pointer=1 (requester 0 wins the first tie), wait counter=0.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: grant = sole valid requester; if both valid, the one != last-grant pointer.
//   o_reqN_ready = (state==IDLE) & granted-to-N (combinational, never both high).
//   Accept = valid&ready at a rising edge: latch a/b/op into o_alu_*, pointer<=N,
//   o_rsp_id<=N, counter<=ALU_LAT, state<=WAIT.
//  WAIT: both readys low. Each edge: if counter==1, o_rsp_data<=i_alu_result,
//   o_rsp_valid<=1, state<=RESP; else counter<=counter-1.
//   Latency: accept at edge k -> o_rsp_valid high after edge k+ALU_LAT.
//  RESP: o_rsp_valid, o_rsp_id and o_rsp_data held stable until i_rsp_ready=1 at an edge;
//   then o_rsp_valid<=0, state<=IDLE. No new accept in the same edge (one bubble cycle).
//  o_alu_* hold their last values outside an accept (ALU output stays observable).
//  Requester valids may drop at any time while not accepted; no state change results.
//  Arithmetic: none in this block; result width NB_DATA, carries/overflow are the ALU's concern.
//  Reset mid-operation: in-flight operation discarded, no response issued, pointer back to 1.
//  Counter sized $clog2(ALU_LAT+1); never wraps (loaded only in IDLE, stops at 1).
// TESTING
//  1 Reset, req0 A=3 B=5 op=100000 -> ready0=1 same cycle, rsp valid after ALU_LAT edges,
//    id=0, data=8.
//  2 req1 A=7 B=2 op=100010 alone -> id=1, data=5; ready0 stays 0 throughout.
//  3 Both valid every cycle (req0 AND 3&3, req1 ADD 1+1) with rsp_ready=1 -> grants alternate
//    0,1,0,1; data 3,2,3,2.
//  4 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/id/data stable, both readys 0, busy=1;
//    release -> IDLE one cycle later.
//  5 Assert reset during WAIT -> rsp_valid never rises, o_alu_*=0, next tie granted to req0.
//  6 ALU_LAT=3, single request -> o_rsp_valid rises exactly 3 edges after accept.

Source files
------------

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// A single operation is in flight at a time: accept, wait ALU_LAT edges, then hold the tagged result.
module alu_req_scheduler #(
    parameter int NB_DATA = 6,
    parameter int NB_OP   = 6,
    parameter int ALU_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_req0_valid,
    input  logic [NB_DATA-1:0] i_req0_a,
    input  logic [NB_DATA-1:0] i_req0_b,
    input  logic [NB_OP-1:0]   i_req0_op,
    output logic               o_req0_ready,
    input  logic               i_req1_valid,
    input  logic [NB_DATA-1:0] i_req1_a,
    input  logic [NB_DATA-1:0] i_req1_b,
    input  logic [NB_OP-1:0]   i_req1_op,
    output logic               o_req1_ready,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_rsp_valid,
    output logic               o_rsp_id,
    output logic [NB_DATA-1:0] o_rsp_data,
    input  logic               i_rsp_ready,
    output logic               o_busy
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              last_grant_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              cnt_last;

    // On a tie the requester that was not served last wins.
    assign grant0   = i_req0_valid & (~i_req1_valid | last_grant_reg);
    assign grant1   = i_req1_valid & (~i_req0_valid | ~last_grant_reg);
    assign cnt_last = (cnt_reg == CNT_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant0 | grant1) state_next = WAIT;
            WAIT:    if (cnt_last)        state_next = RESP;
            RESP:    if (i_rsp_ready)     state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_busy       = 1'b1;
        if (state_reg == IDLE) begin
            o_req0_ready = grant0;
            o_req1_ready = grant1;
            o_busy       = 1'b0;
        end
    end

    assign accept = o_req0_ready | o_req1_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_alu_a        <= '0;
            o_alu_b        <= '0;
            o_alu_op       <= '0;
            last_grant_reg <= 1'b1;
            o_rsp_id       <= 1'b0;
            cnt_reg        <= '0;
            o_rsp_data     <= '0;
            o_rsp_valid    <= 1'b0;
        end else begin
            if (accept) begin
                o_alu_a        <= grant1 ? i_req1_a  : i_req0_a;
                o_alu_b        <= grant1 ? i_req1_b  : i_req0_b;
                o_alu_op       <= grant1 ? i_req1_op : i_req0_op;
                last_grant_reg <= grant1;
                o_rsp_id       <= grant1;
                cnt_reg        <= CNT_W'(ALU_LAT);
            end
            if (state_reg == WAIT) begin
                if (cnt_last) begin
                    o_rsp_data  <= i_alu_result;
                    o_rsp_valid <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
            if ((state_reg == RESP) && i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler: stimulus pushes expected tagged results,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_req_scheduler;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [5:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic [5:0] alu_a, alu_b, alu_op, alu_result, rsp_data;
    logic       rsp_valid, rsp_id, rsp_ready, busy;

    logic       t3_req0_valid, t3_req1_valid, t3_req0_ready, t3_req1_ready;
    logic [5:0] t3_req0_a, t3_req0_b, t3_req0_op, t3_req1_a, t3_req1_b, t3_req1_op;
    logic [5:0] t3_alu_a, t3_alu_b, t3_alu_op, t3_alu_result, t3_rsp_data;
    logic       t3_rsp_valid, t3_rsp_id, t3_rsp_ready, t3_busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_edge = 0;
    logic       prev_valid = 1'b0;
    logic [6:0] sb[$];
    logic [5:0] exp_data [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [5:0] alu_f(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return 6'd0;
        endcase
    endfunction

    assign alu_result    = alu_f(alu_a, alu_b, alu_op);
    assign t3_alu_result = alu_f(t3_alu_a, t3_alu_b, t3_alu_op);

    alu_req_scheduler #(.NB_DATA(6), .NB_OP(6), .ALU_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .i_req0_valid(req0_valid), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_op(req0_op),
        .o_req0_ready(req0_ready),
        .i_req1_valid(req1_valid), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_op(req1_op),
        .o_req1_ready(req1_ready),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_result(alu_result),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
        .i_rsp_ready(rsp_ready), .o_busy(busy)
    );

    alu_req_scheduler #(.NB_DATA(6), .NB_OP(6), .ALU_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .i_req0_valid(t3_req0_valid), .i_req0_a(t3_req0_a), .i_req0_b(t3_req0_b), .i_req0_op(t3_req0_op),
        .o_req0_ready(t3_req0_ready),
        .i_req1_valid(t3_req1_valid), .i_req1_a(t3_req1_a), .i_req1_b(t3_req1_b), .i_req1_op(t3_req1_op),
        .o_req1_ready(t3_req1_ready),
        .o_alu_a(t3_alu_a), .o_alu_b(t3_alu_b), .o_alu_op(t3_alu_op), .i_alu_result(t3_alu_result),
        .o_rsp_valid(t3_rsp_valid), .o_rsp_id(t3_rsp_id), .o_rsp_data(t3_rsp_data),
        .i_rsp_ready(t3_rsp_ready), .o_busy(t3_busy)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pushes on request handshakes, pops on response handshakes.
    always @(negedge clock) begin
        if (!reset) begin
            sb.delete();
            prev_valid <= 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, exp_data[0]});
                acc_edge <= cyc + 1;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, exp_data[1]});
                acc_edge <= cyc + 1;
            end
            if (rsp_valid && !prev_valid) chk("latency", cyc - acc_edge, 1);
            if (rsp_valid && rsp_ready) begin
                $display("rsp id=%0d data=%0d", rsp_id, rsp_data);
                chk("sb_has_entry", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("rsp_id", int'(rsp_id), int'(sb[0][6]));
                    chk("rsp_data", int'(rsp_data), int'(sb[0][5:0]));
                    void'(sb.pop_front());
                end
            end
            prev_valid <= rsp_valid;
        end
    end

    task automatic wait_hs(input bit id, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 20) begin
            @(negedge clock);
            hit = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
            n++;
        end
        chk({name, "_accept"}, int'(hit), 1);
    endtask

    task automatic send(input bit id, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] op, input logic [5:0] e, input string name);
        @(posedge clock); #1;
        exp_data[id] = e;
        if (!id) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        #1 chk({name, "_ready_now"}, int'(id ? req1_ready : req0_ready), 1);
        wait_hs(id, name);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clock);
            done = (sb.size() == 0) && !rsp_valid;
            n++;
        end
        chk({name, "_drained"}, int'(done), 1);
    endtask

    initial begin
        int n;
        int guard;
        reset = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 1'b1;
        t3_req0_valid = 0; t3_req1_valid = 0; t3_rsp_ready = 1'b1;
        t3_req0_a = 0; t3_req0_b = 0; t3_req0_op = 0; t3_req1_a = 0; t3_req1_b = 0; t3_req1_op = 0;
        exp_data[0] = 0; exp_data[1] = 0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock); #1 reset = 1'b1;

        // Single requests
        send(1'b0, 6'd3, 6'd5, OP_ADD, 6'd8, "t1");
        drain("t1");
        send(1'b1, 6'd7, 6'd2, OP_SUB, 6'd5, "t2");
        repeat (3) begin
            @(negedge clock);
            chk("t2_ready0", req0_ready, 0);
        end
        drain("t2");

        // Contention: grants must alternate starting with requester 0
        @(posedge clock); #1;
        exp_data[0] = 6'd3; exp_data[1] = 6'd2;
        req0_a = 6'd3; req0_b = 6'd3; req0_op = OP_AND; req0_valid = 1'b1;
        req1_a = 6'd1; req1_b = 6'd1; req1_op = OP_ADD; req1_valid = 1'b1;
        n = 0;
        guard = 0;
        while (n < 4 && guard < 60) begin
            @(negedge clock);
            guard++;
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                chk("t3_grant_id", req1_ready, n % 2);
                chk("t3_one_ready", int'(req0_ready) + int'(req1_ready), 1);
                n++;
            end
        end
        chk("t3_accepts", n, 4);
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("t3");

        // Back-pressure in RESP
        rsp_ready = 1'b0;
        send(1'b0, 6'd6, 6'd1, OP_SUB, 6'd5, "t4");
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("t4_rsp_seen", rsp_valid, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_id", rsp_id, 0);
            chk("t4_hold_data", rsp_data, 5);
            chk("t4_hold_ready0", req0_ready, 0);
            chk("t4_hold_ready1", req1_ready, 0);
            chk("t4_hold_busy", busy, 1);
        end
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_valid", rsp_valid, 0);

        // Reset while waiting on the ALU
        send(1'b0, 6'd3, 6'd5, OP_ADD, 6'd8, "t5");
        reset = 1'b0;
        #1;
        chk("t5_alu_a", alu_a, 0);
        chk("t5_alu_b", alu_b, 0);
        chk("t5_alu_op", alu_op, 0);
        chk("t5_busy", busy, 0);
        repeat (3) begin
            @(negedge clock);
            chk("t5_no_rsp", rsp_valid, 0);
        end
        @(posedge clock); #1 reset = 1'b1;
        exp_data[0] = 6'd4; exp_data[1] = 6'd3;
        req0_a = 6'd5; req0_b = 6'd6; req0_op = OP_AND; req0_valid = 1'b1;
        req1_a = 6'd1; req1_b = 6'd2; req1_op = OP_ADD; req1_valid = 1'b1;
        #1;
        chk("t5_tie_ready0", req0_ready, 1);
        chk("t5_tie_ready1", req1_ready, 0);
        wait_hs(1'b0, "t5_tie");
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("t5");

        // Longer ALU latency
        @(posedge clock); #1;
        t3_req0_a = 6'd3; t3_req0_b = 6'd5; t3_req0_op = OP_ADD; t3_req0_valid = 1'b1;
        #1 chk("t6_ready_now", t3_req0_ready, 1);
        guard = 0;
        while (!(t3_req0_valid && t3_req0_ready) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("t6_accept", int'(t3_req0_ready), 1);
        n = cyc + 1;
        @(posedge clock); #1 t3_req0_valid = 1'b0;
        guard = 0;
        while (!t3_rsp_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("t6_latency", cyc - n, 3);
        chk("t6_rsp_data", t3_rsp_data, 8);
        chk("t6_rsp_id", t3_rsp_id, 0);
        $display("lat3 rsp id=%0d data=%0d", t3_rsp_id, t3_rsp_data);
        repeat (3) @(negedge clock);
        chk("t6_idle", t3_busy, 0);

        drain("end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
